// File: rtl/ir_rc5_transmitter_if.sv
// Handshake and line signals between the command source and the IR frame transmitter.
// The master drives Start/Address/Command and the transmitter drives the line and status.
interface ir_rc5_transmitter_if;
    logic       Start;
    logic [4:0] Address;
    logic [5:0] Command;
    logic       Data;
    logic       Busy;
    logic       Done;
    logic       Toggle;

    modport master (output Start, Address, Command, input Data, Busy, Done, Toggle);
    modport slave  (input Start, Address, Command, output Data, Busy, Done, Toggle);
endinterface

// File: rtl/ir_rc5_transmitter.sv
// IR command frame transmitter: preamble H L H, then toggle, address and command bits,
// Manchester encoded LSB first, followed by an idle gap. Define IR_TX_CARRIER_EN to modulate Data.
module ir_rc5_transmitter #(
    parameter int HALF_BIT_CYCLES = 1024,
    parameter int GAP_HALF_BITS   = 8,
    parameter int CARRIER_DIV     = 16
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    ir_rc5_transmitter_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, GAP, DONE} state_t;

    localparam logic [11:0] HALF_LAST = 12'(HALF_BIT_CYCLES - 1);
    localparam logic [7:0]  GAP_LAST  = 8'(GAP_HALF_BITS - 1);

    if (HALF_BIT_CYCLES < 2 || HALF_BIT_CYCLES > 4095 || GAP_HALF_BITS < 1 ||
        GAP_HALF_BITS > 255 || CARRIER_DIV < 1 || CARRIER_DIV > 4096) begin : gBadParams
        $error("ir_rc5_transmitter: parameter out of range");
    end

    state_t      state;
    logic [11:0] halfCnt;
    logic [7:0]  halfIdx;
    logic [11:0] frame;
    logic        baseband;
    logic        busyR;
    logic        doneR;
    logic        toggleR;
    logic        halfWrap;
    logic [7:0]  idxNext;
    logic        baseNext;

    assign halfWrap = (halfCnt == HALF_LAST);
    assign idxNext  = halfIdx + 8'd1;

    // Baseband level for the next cycle; it only moves on a half-bit wrap or a state change.
    always_comb begin
        baseNext = 1'b0;
        case (state)
            IDLE:     baseNext = bus.Start;
            PREAMBLE: begin
                if (!halfWrap)             baseNext = baseband;
                else if (halfIdx == 8'd2)  baseNext = frame[0];
                else                       baseNext = halfIdx[0];
            end
            DATA: begin
                if (!halfWrap)             baseNext = baseband;
                else if (halfIdx == 8'd23) baseNext = 1'b0;
                else                       baseNext = frame[idxNext[4:1]] ^ idxNext[0];
            end
            GAP:      baseNext = 1'b0;
            DONE:     baseNext = 1'b0;
            default:  baseNext = 1'b0;
        endcase
    end

    // Frame sequencer with registered status outputs.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state    <= IDLE;
            halfCnt  <= 12'd0;
            halfIdx  <= 8'd0;
            frame    <= 12'd0;
            baseband <= 1'b0;
            busyR    <= 1'b0;
            doneR    <= 1'b0;
            toggleR  <= 1'b0;
        end else begin
            baseband <= baseNext;
            doneR    <= 1'b0;
            halfCnt  <= halfWrap ? 12'd0 : halfCnt + 12'd1;
            if (halfWrap) halfIdx <= idxNext;
            case (state)
                IDLE: begin
                    halfCnt <= 12'd0;
                    halfIdx <= 8'd0;
                    busyR   <= 1'b0;
                    if (bus.Start) begin
                        frame <= {bus.Command, bus.Address, toggleR};
                        busyR <= 1'b1;
                        state <= PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    if (halfWrap && halfIdx == 8'd2) begin
                        halfIdx <= 8'd0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (halfWrap && halfIdx == 8'd23) begin
                        halfIdx <= 8'd0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (halfWrap && halfIdx == GAP_LAST) begin
                        busyR   <= 1'b0;
                        doneR   <= 1'b1;
                        toggleR <= ~toggleR;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    halfCnt <= 12'd0;
                    halfIdx <= 8'd0;
                    state   <= IDLE;
                end
                default: begin
                    busyR <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IR_TX_CARRIER_EN
    localparam logic [11:0] CARRIER_LAST = 12'(CARRIER_DIV - 1);

    logic [11:0] carrierCnt;
    logic        carrierLvl;

    // Carrier restarts high on every rising baseband edge so each burst has the same phase.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            carrierCnt <= 12'd0;
            carrierLvl <= 1'b0;
        end else if (baseNext && !baseband) begin
            carrierCnt <= 12'd0;
            carrierLvl <= 1'b1;
        end else if (baseNext) begin
            if (carrierCnt == CARRIER_LAST) begin
                carrierCnt <= 12'd0;
                carrierLvl <= ~carrierLvl;
            end else begin
                carrierCnt <= carrierCnt + 12'd1;
            end
        end else begin
            carrierCnt <= 12'd0;
            carrierLvl <= 1'b0;
        end
    end

    assign bus.Data = carrierLvl;
`else
    assign bus.Data = baseband;
`endif

    assign bus.Busy   = busyR;
    assign bus.Done   = doneR;
    assign bus.Toggle = toggleR;

endmodule

// File: tb/tb_ir_rc5_transmitter.sv
// Scoreboard bench: stimulus queues hand-computed 12-bit frames, a negedge monitor
// captures every frame's line pattern and checks it when Done appears.
module tb_ir_rc5_transmitter;

    localparam int HB   = 4;
    localparam int GAP  = 8;
    localparam int NCYC = (27 + GAP) * HB;

    typedef struct {
        logic [11:0] frame;
        logic        togAfter;
    } exp_t;

    logic Clock;
    logic Reset_n;
    ir_rc5_transmitter_if bus ();

    ir_rc5_transmitter #(.HALF_BIT_CYCLES(HB), .GAP_HALF_BITS(GAP), .CARRIER_DIV(2)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clock = ~Clock;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [NCYC-1:0] expand(input logic [11:0] f);
        logic [NCYC-1:0] v;
        v = '0;
        for (int c = 0; c < 27 * HB; c++) begin
            int h;
            h = c / HB;
            if (h < 3) v[c] = (h != 1);
            else       v[c] = f[(h - 3) / 2] ^ (((h - 3) % 2) == 1);
        end
        return v;
    endfunction

    // Monitor: collect Data while Busy, score the frame on Done.
    logic [NCYC-1:0] actBits;
    int              nSamp      = 0;
    bit              collecting = 0;
    bit              prevDone   = 0;

    always @(negedge Clock) begin
        exp_t e;
        if (prevDone) check("done_width", {31'd0, bus.Done}, 32'd0);
        prevDone = bus.Done;
        if (bus.Busy) begin
            if (!collecting) begin
                collecting = 1;
                nSamp      = 0;
                actBits    = '0;
            end
            if (nSamp < NCYC) actBits[nSamp] = bus.Data;
            nSamp++;
        end else begin
            if (bus.Done) begin
                check("done_expected", {31'd0, expQ.size() > 0}, 32'd1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    check("busy_length", nSamp, NCYC);
                    checks++;
                    if (actBits !== expand(e.frame)) begin
                        failures++;
                        $display("FAIL frame_bits %03h: got %h, expected %h",
                                 e.frame, actBits, expand(e.frame));
                    end
                    check("toggle_at_done", {31'd0, bus.Toggle}, {31'd0, e.togAfter});
                end
            end
            collecting = 0;
        end
    end

    task automatic waitDone(input int maxCyc);
        int n;
        n = 0;
        @(negedge Clock);
        while (!bus.Done && n < maxCyc) begin
            @(negedge Clock);
            n++;
        end
        check("done_seen", {31'd0, bus.Done}, 32'd1);
    endtask

    task automatic startFrame(input logic [4:0] a, input logic [5:0] c);
        bus.Address = a;
        bus.Command = c;
        bus.Start   = 1'b1;
        @(negedge Clock);
        bus.Start   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        Clock       = 1'b0;
        Reset_n     = 1'b0;
        bus.Start   = 1'b0;
        bus.Address = 5'd0;
        bus.Command = 6'd0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("reset_outputs", {28'd0, bus.Data, bus.Busy, bus.Done, bus.Toggle}, 32'd0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clock);

        // All-zero frame, toggle 0
        expQ.push_back('{12'h000, 1'b1});
        startFrame(5'h00, 6'h00);
        check("start_latency", {30'd0, bus.Data, bus.Busy}, 32'd3);
        waitDone(300);
        repeat (2) @(negedge Clock);

        // Right command, toggle 1; inputs scrambled and Start re-pulsed mid-frame
        expQ.push_back('{12'h0ED, 1'b0});
        startFrame(5'b10110, 6'b000011);
        repeat (19) @(negedge Clock);
        bus.Address = 5'h1F;
        bus.Command = 6'h3F;
        bus.Start   = 1'b1;
        @(negedge Clock);
        bus.Start   = 1'b0;
        waitDone(300);
        repeat (2) @(negedge Clock);

        // Left command, toggle 0
        expQ.push_back('{12'h086, 1'b1});
        startFrame(5'h03, 6'h02);
        waitDone(300);
        repeat (2) @(negedge Clock);

        // Abort at half-bit 10 with Toggle=1; no Done may follow
        startFrame(5'h1F, 6'h3F);
        repeat (40) @(negedge Clock);
        Reset_n = 1'b0;
        @(negedge Clock);
        check("abort_outputs", {28'd0, bus.Data, bus.Busy, bus.Done, bus.Toggle}, 32'd0);
        Reset_n = 1'b1;
        repeat (10) @(negedge Clock);

        // Full frame after the abort, toggle 0
        expQ.push_back('{12'hAAA, 1'b1});
        startFrame(5'h15, 6'h2A);
        waitDone(300);
        repeat (2) @(negedge Clock);

        // Start held high: three back-to-back frames carrying toggle 0,1,0
        Reset_n = 1'b0;
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);
        expQ.push_back('{12'h046, 1'b1});
        expQ.push_back('{12'h047, 1'b0});
        expQ.push_back('{12'h046, 1'b1});
        bus.Address = 5'h03;
        bus.Command = 6'h01;
        bus.Start   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            waitDone(300);
            if (i == 2) begin
                bus.Start = 1'b0;
            end else begin
                n = 0;
                do begin
                    @(negedge Clock);
                    n++;
                end while (!bus.Data && n < 10);
                check("b2b_gap", n, 2);
            end
        end
        repeat (20) @(negedge Clock);
        check("queue_empty", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
